uart_bus_bridge: RTL and testbench

//   Host-side responder for the UART FIFO peripheral. Drains its RX FIFO and parses command frames from the PC.

---
 rtl/uart_bus_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_bridge.sv
// UART-to-bus bridge: parses W/R command frames from the RX FIFO, runs a single
// 16-bit bus transaction, and pushes the reply bytes into the TX FIFO.
module uart_bus_bridge #(
    parameter int unsigned BUS_TIMEOUT = 1024,
    parameter logic [7:0]  CMD_WRITE   = 8'h57,
    parameter logic [7:0]  CMD_READ    = 8'h52
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_fifo_empty,
    output logic        rx_fifo_pop,
    output logic [7:0]  tx_byte,
    output logic        transmit,
    input  logic        tx_fifo_full,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_req,
    input  logic        bus_ack,
    input  logic [15:0] bus_rdata,
    output logic        busy,
    output logic        err
);

    localparam int unsigned TW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(BUS_TIMEOUT - 1);

    localparam logic [7:0] RESP_OK  = 8'h4B;
    localparam logic [7:0] RESP_ERR = 8'h45;
    localparam logic [7:0] RESP_BAD = 8'h3F;

    typedef enum logic [2:0] {StIdle, StPopWait, StOperand, StBus, StResp} state_e;

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          req_q, req_d;
    logic [15:0]   rdata_q, rdata_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    code_q, code_d;
    logic [1:0]    len_q, len_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          transmit_q, transmit_d;
    logic          err_q, err_d;
    logic          pop;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            req_q      <= 1'b0;
            rdata_q    <= '0;
            tmo_q      <= '0;
            code_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            tx_byte_q  <= '0;
            transmit_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            req_q      <= req_d;
            rdata_q    <= rdata_d;
            tmo_q      <= tmo_d;
            code_q     <= code_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            tx_byte_q  <= tx_byte_d;
            transmit_q <= transmit_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic: frame parsing, bus handshake, reply sequencing
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        req_d      = req_q;
        rdata_d    = rdata_q;
        tmo_d      = tmo_q;
        code_d     = code_q;
        len_d      = len_q;
        idx_d      = idx_q;
        tx_byte_d  = tx_byte_q;
        transmit_d = 1'b0;
        err_d      = 1'b0;
        pop        = 1'b0;

        case (state_q)
            StIdle: begin
                if (!rx_fifo_empty) begin
                    pop   = 1'b1;
                    cnt_d = '0;
                    if (rx_byte == CMD_WRITE) begin
                        we_d    = 1'b1;
                        state_d = StPopWait;
                    end else if (rx_byte == CMD_READ) begin
                        we_d    = 1'b0;
                        state_d = StPopWait;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = RESP_BAD;
                        len_d   = 2'd1;
                        idx_d   = '0;
                        state_d = StResp;
                    end
                end
            end

            // Gives the RX FIFO one cycle to update its status after a pop
            StPopWait: state_d = StOperand;

            StOperand: begin
                if (!rx_fifo_empty) begin
                    pop = 1'b1;
                    case (cnt_q)
                        2'd0:    addr_d[15:8]  = rx_byte;
                        2'd1:    addr_d[7:0]   = rx_byte;
                        2'd2:    wdata_d[15:8] = rx_byte;
                        default: wdata_d[7:0]  = rx_byte;
                    endcase
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == (we_q ? 2'd3 : 2'd1)) begin
                        req_d   = 1'b1;
                        tmo_d   = '0;
                        state_d = StBus;
                    end else begin
                        state_d = StPopWait;
                    end
                end
            end

            // Ack is checked before expiry so a last-cycle ack still succeeds
            StBus: begin
                if (bus_ack && req_q) begin
                    req_d   = 1'b0;
                    rdata_d = bus_rdata;
                    code_d  = RESP_OK;
                    len_d   = we_q ? 2'd1 : 2'd3;
                    idx_d   = '0;
                    state_d = StResp;
                end else if (tmo_q == TMO_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    code_d  = RESP_ERR;
                    len_d   = 2'd1;
                    idx_d   = '0;
                    state_d = StResp;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            // Skipping the cycle after a pulse lets tx_fifo_full catch up
            StResp: begin
                if (!transmit_q && !tx_fifo_full) begin
                    transmit_d = 1'b1;
                    case (idx_q)
                        2'd0:    tx_byte_d = code_q;
                        2'd1:    tx_byte_d = rdata_q[15:8];
                        default: tx_byte_d = rdata_q[7:0];
                    endcase
                    idx_d = idx_q + 2'd1;
                    if (idx_q == len_q - 2'd1) begin
                        state_d = StIdle;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // Output mapping; pop is held low while reset is asserted
    always_comb begin
        rx_fifo_pop = pop & rst;
        tx_byte     = tx_byte_q;
        transmit    = transmit_q;
        bus_addr    = addr_q;
        bus_wdata   = wdata_q;
        bus_we      = we_q;
        bus_req     = req_q;
        busy        = (state_q != StIdle);
        err         = err_q;
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge with RX FIFO model and TX/bus scoreboards.
module tb_uart_bus_bridge;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_fifo_empty = 1'b1;
    logic        rx_fifo_pop;
    logic [7:0]  tx_byte;
    logic        transmit;
    logic        tx_fifo_full = 1'b0;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_we;
    logic        bus_req;
    logic        bus_ack = 1'b0;
    logic [15:0] bus_rdata = 16'h0000;
    logic        busy;
    logic        err;

    uart_bus_bridge #(.BUS_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_byte      (rx_byte),
        .rx_fifo_empty(rx_fifo_empty),
        .rx_fifo_pop  (rx_fifo_pop),
        .tx_byte      (tx_byte),
        .transmit     (transmit),
        .tx_fifo_full (tx_fifo_full),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_we       (bus_we),
        .bus_req      (bus_req),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        we;
    } bus_t;

    int          total = 0;
    int          bad = 0;
    int          err_cnt = 0;
    int          req_run = 0;
    int          last_req_len = 0;
    logic        tx_prev = 1'b0;
    logic        req_prev = 1'b0;
    logic        pend = 1'b0;
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_exp[$];
    bus_t        bus_exp[$];
    bus_t        be;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // RX FIFO model: a pop seen during a cycle takes effect after that cycle's posedge
    always @(negedge clk) begin
        if (pend && rx_q.size() > 0) void'(rx_q.pop_front());
        rx_fifo_empty = (rx_q.size() == 0);
        rx_byte       = rx_fifo_empty ? 8'h00 : rx_q[0];
        #1 pend = rx_fifo_pop;
    end

    // Output monitor: TX scoreboard, bus request scoreboard, err and req-length tracking
    always @(negedge clk) begin
        if (err) err_cnt++;
        if (transmit) begin
            chk("tx_while_full", {31'd0, tx_fifo_full}, 32'd0);
            chk("tx_gap", {31'd0, tx_prev}, 32'd0);
            total++;
            assert (tx_exp.size() != 0) else begin
                bad++;
                $error("FAIL tx_extra got=%0h exp=none", tx_byte);
            end
            if (tx_exp.size() != 0) chk("tx_byte", {24'd0, tx_byte}, {24'd0, tx_exp.pop_front()});
        end
        tx_prev = transmit;
        if (bus_req && !req_prev) begin
            total++;
            assert (bus_exp.size() != 0) else begin
                bad++;
                $error("FAIL bus_extra got=%0h exp=none", bus_addr);
            end
            if (bus_exp.size() != 0) begin
                be = bus_exp.pop_front();
                chk("bus_addr", {16'd0, bus_addr}, {16'd0, be.addr});
                chk("bus_we", {31'd0, bus_we}, {31'd0, be.we});
                if (be.we) chk("bus_wdata", {16'd0, bus_wdata}, {16'd0, be.wdata});
            end
        end
        if (bus_req) begin
            req_run++;
        end else if (req_run != 0) begin
            last_req_len = req_run;
            req_run = 0;
        end
        req_prev = bus_req;
    end

    task automatic push_rx(input logic [7:0] b);
        rx_q.push_back(b);
    endtask

    task automatic do_ack(input int dly, input logic [15:0] rd);
        int n = 0;
        while (!bus_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ack_wait_req", {31'd0, bus_req}, 32'd1);
        if (bus_req) begin
            repeat (dly) @(negedge clk);
            bus_ack   = 1'b1;
            bus_rdata = rd;
            @(negedge clk);
            bus_ack   = 1'b0;
            bus_rdata = 16'h0000;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rx_q.size() == 0 && !busy && tx_exp.size() == 0) && n < 500);
        repeat (2) @(negedge clk);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_tx_left"}, tx_exp.size(), 32'd0);
        chk({tag, "_bus_left"}, bus_exp.size(), 32'd0);
    endtask

    int e0;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pop", {31'd0, rx_fifo_pop}, 32'd0);
        chk("rst_transmit", {31'd0, transmit}, 32'd0);
        chk("rst_req", {31'd0, bus_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_addr", {16'd0, bus_addr}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: write 1234 <= ABCD, ack after 3 cycles
        e0 = err_cnt;
        bus_exp.push_back('{addr: 16'h1234, wdata: 16'hABCD, we: 1'b1});
        tx_exp.push_back(8'h4B);
        push_rx(8'h57); push_rx(8'h12); push_rx(8'h34); push_rx(8'hAB); push_rx(8'hCD);
        do_ack(3, 16'h0000);
        wait_idle("t1");
        chk("t1_err", err_cnt - e0, 32'd0);

        // 2: read 0010 -> BEEF
        bus_exp.push_back('{addr: 16'h0010, wdata: 16'h0000, we: 1'b0});
        tx_exp.push_back(8'h4B); tx_exp.push_back(8'hBE); tx_exp.push_back(8'hEF);
        push_rx(8'h52); push_rx(8'h00); push_rx(8'h10);
        do_ack(0, 16'hBEEF);
        wait_idle("t2");

        // 3: read with no ack -> timeout reply
        e0 = err_cnt;
        bus_exp.push_back('{addr: 16'h0040, wdata: 16'h0000, we: 1'b0});
        tx_exp.push_back(8'h45);
        push_rx(8'h52); push_rx(8'h00); push_rx(8'h40);
        wait_idle("t3");
        chk("t3_req_len", last_req_len, TMO);
        chk("t3_err", err_cnt - e0, 32'd1);

        // 4: stray ack ignored; bad opcode then a valid read
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_stray_ack_busy", {31'd0, busy}, 32'd0);
        e0 = err_cnt;
        tx_exp.push_back(8'h3F);
        bus_exp.push_back('{addr: 16'h0001, wdata: 16'h0000, we: 1'b0});
        tx_exp.push_back(8'h4B); tx_exp.push_back(8'h5A); tx_exp.push_back(8'hA5);
        push_rx(8'h00); push_rx(8'h52); push_rx(8'h00); push_rx(8'h01);
        do_ack(1, 16'h5AA5);
        wait_idle("t4");
        chk("t4_err", err_cnt - e0, 32'd1);

        // 5: TX FIFO full for 50 cycles during read reply
        tx_fifo_full = 1'b1;
        bus_exp.push_back('{addr: 16'h0030, wdata: 16'h0000, we: 1'b0});
        tx_exp.push_back(8'h4B); tx_exp.push_back(8'h12); tx_exp.push_back(8'h34);
        push_rx(8'h52); push_rx(8'h00); push_rx(8'h30);
        do_ack(1, 16'h1234);
        repeat (50) @(negedge clk);
        chk("t5_held", tx_exp.size(), 32'd3);
        chk("t5_busy", {31'd0, busy}, 32'd1);
        tx_fifo_full = 1'b0;
        wait_idle("t5");

        // 6: reset in the middle of a write frame, then a fresh read
        push_rx(8'h57); push_rx(8'h12);
        for (int n = 0; n < 50 && rx_q.size() != 0; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("t6_busy_mid", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_req", {31'd0, bus_req}, 32'd0);
        chk("t6_we", {31'd0, bus_we}, 32'd0);
        chk("t6_addr", {16'd0, bus_addr}, 32'd0);
        chk("t6_transmit", {31'd0, transmit}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus_exp.push_back('{addr: 16'h0020, wdata: 16'h0000, we: 1'b0});
        tx_exp.push_back(8'h4B); tx_exp.push_back(8'h13); tx_exp.push_back(8'h57);
        push_rx(8'h52); push_rx(8'h00); push_rx(8'h20);
        do_ack(2, 16'h1357);
        wait_idle("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
